// File: rtl/fmul_iter_if.sv
// Operand-issue / result-writeback bundle for fmul_iter.
// Handshake: a transfer happens on a rising clk edge where valid && ready; the source holds its payload stable until then.
interface fmul_iter_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         round_mode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] re;
    logic [3:0]   flags;

    modport master (
        output in_valid, op_a, op_b, round_mode, out_ready,
        input  in_ready, out_valid, re, flags
    );

    modport slave (
        input  in_valid, op_a, op_b, round_mode, out_ready,
        output in_ready, out_valid, re, flags
    );
endinterface

// File: rtl/fmul_iter.sv
// Multi-cycle floating-point multiplier: shift-add mantissa product, one normalise
// cycle and one round cycle, with special operands resolved at issue.
module fmul_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic       clk,
    input  logic       rst_n,
    fmul_iter_if.slave bus,
    output logic [2:0] state_o
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int M  = MAN_W + 1;
    localparam int P  = 2 * M;
    localparam int XW = EXP_W + 2;
    localparam int CW = $clog2(M + 1);

    localparam logic [EXP_W-1:0]        EXP_ONES = '1;
    localparam logic [EXP_W-1:0]        EXP_MAXF = EXP_ONES - 1'b1;
    localparam logic signed [XW-1:0]    BIAS     = XW'(2 ** (EXP_W - 1) - 1);
    localparam logic signed [XW-1:0]    EMAX     = XW'(2 ** EXP_W - 1);
    localparam logic signed [XW-1:0]    EZERO    = '0;
    localparam logic [W-1:0]            QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        NORM = 3'd2,
        RND  = 3'd3,
        OUT  = 3'd4
    } state_t;

    state_t                 state_q;
    logic                   sign_q;
    logic                   rm_q;
    logic [P-1:0]           mcand_q;
    logic [M-1:0]           mplier_q;
    logic [P-1:0]           acc_q;
    logic [CW-1:0]          cnt_q;
    logic signed [XW-1:0]   exp_q;
    logic [MAN_W-1:0]       frac_q;
    logic                   guard_q;
    logic                   sticky_q;
    logic [W-1:0]           re_q;
    logic [3:0]             flags_q;

    // Operand classification on the live bus, used only in the accepting cycle
    logic                   a_sign, b_sign, in_sign;
    logic [EXP_W-1:0]       a_exp, b_exp;
    logic [MAN_W-1:0]       a_frac, b_frac;
    logic                   a_nan, b_nan, a_snan, b_snan;
    logic                   a_inf, b_inf, a_zero, b_zero, special;
    logic signed [XW-1:0]   exp_init;

    assign a_sign  = bus.op_a[W-1];
    assign b_sign  = bus.op_b[W-1];
    assign a_exp   = bus.op_a[W-2:MAN_W];
    assign b_exp   = bus.op_b[W-2:MAN_W];
    assign a_frac  = bus.op_a[MAN_W-1:0];
    assign b_frac  = bus.op_b[MAN_W-1:0];
    assign in_sign = a_sign ^ b_sign;
    assign a_nan   = (&a_exp) && (|a_frac);
    assign b_nan   = (&b_exp) && (|b_frac);
    assign a_snan  = a_nan && !a_frac[MAN_W-1];
    assign b_snan  = b_nan && !b_frac[MAN_W-1];
    assign a_inf   = (&a_exp) && !(|a_frac);
    assign b_inf   = (&b_exp) && !(|b_frac);
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign special = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
    assign exp_init = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS;

    logic [W-1:0] spec_re;
    logic [3:0]   spec_flags;

    always_comb begin
        spec_re    = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_re    = QNAN;
            spec_flags = {a_snan || b_snan, 3'b000};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            spec_re    = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf || b_inf) begin
            spec_re = {in_sign, EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_re = {in_sign, {(W-1){1'b0}}};
        end
    end

    // Product lies in [1,4): bit P-1 set means the value is >= 2
    logic [MAN_W-1:0]     norm_frac;
    logic                 norm_guard;
    logic                 norm_sticky;
    logic signed [XW-1:0] norm_exp;

    always_comb begin
        norm_frac   = '0;
        norm_guard  = 1'b0;
        norm_sticky = 1'b0;
        if (acc_q[P-1]) begin
            norm_frac   = acc_q[P-2 -: MAN_W];
            norm_guard  = acc_q[P-2-MAN_W];
            norm_sticky = |acc_q[P-3-MAN_W:0];
        end else begin
            norm_frac   = acc_q[P-3 -: MAN_W];
            norm_guard  = acc_q[P-3-MAN_W];
            norm_sticky = |acc_q[P-4-MAN_W:0];
        end
        norm_exp = exp_q + $signed({{(XW-1){1'b0}}, acc_q[P-1]});
    end

    logic                 rnd_inc;
    logic [MAN_W:0]       rnd_sum;
    logic signed [XW-1:0] rnd_exp;
    logic [W-1:0]         rnd_re;
    logic [3:0]           rnd_flags;

    always_comb begin
        rnd_inc   = !rm_q && guard_q && (sticky_q || frac_q[0]);
        rnd_sum   = {1'b0, frac_q} + {{MAN_W{1'b0}}, rnd_inc};
        rnd_exp   = exp_q + $signed({{(XW-1){1'b0}}, rnd_sum[MAN_W]});
        rnd_re    = {sign_q, rnd_exp[EXP_W-1:0], rnd_sum[MAN_W-1:0]};
        rnd_flags = {3'b000, guard_q || sticky_q};
        if (rnd_exp >= EMAX) begin
            rnd_flags = 4'b0101;
            rnd_re    = rm_q ? {sign_q, EXP_MAXF, {MAN_W{1'b1}}}
                             : {sign_q, EXP_ONES, {MAN_W{1'b0}}};
        end else if (rnd_exp <= EZERO) begin
            rnd_flags = 4'b0011;
            rnd_re    = {sign_q, {(W-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            rm_q     <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            exp_q    <= '0;
            frac_q   <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            re_q     <= '0;
            flags_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sign_q   <= in_sign;
                        rm_q     <= bus.round_mode;
                        mcand_q  <= {{M{1'b0}}, 1'b1, a_frac};
                        mplier_q <= {1'b1, b_frac};
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        exp_q    <= exp_init;
                        if (special) begin
                            re_q    <= spec_re;
                            flags_q <= spec_flags;
                            state_q <= OUT;
                        end else begin
                            state_q <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(M - 1)) begin
                        state_q <= NORM;
                    end
                end
                NORM: begin
                    frac_q   <= norm_frac;
                    guard_q  <= norm_guard;
                    sticky_q <= norm_sticky;
                    exp_q    <= norm_exp;
                    state_q  <= RND;
                end
                RND: begin
                    re_q    <= rnd_re;
                    flags_q <= rnd_flags;
                    state_q <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == OUT);
    assign bus.re        = re_q;
    assign bus.flags     = flags_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_fmul_iter.sv
// Bench for fmul_iter at default (binary32) parameters: directed vector table,
// backpressure and mid-operation reset sequences, and randomized operands against a reference model.
module tb_fmul_iter;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic       clk;
    logic       rst_n;
    logic [2:0] state;

    fmul_iter_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fmul_iter #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .state_o(state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [W+3:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference: exact integer product, rounding by remainder comparison
    function automatic logic [W+3:0] model(input logic [31:0] a, input logic [31:0] b, input logic rm);
        logic s;
        logic [7:0] ea, eb;
        logic [22:0] fa, fb;
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned prod, q, rem, half;
        int e, sh;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        a_nan  = (ea == 8'hFF) && (fa != 0);
        b_nan  = (eb == 8'hFF) && (fb != 0);
        a_inf  = (ea == 8'hFF) && (fa == 0);
        b_inf  = (eb == 8'hFF) && (fb == 0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan)
            return {((a_nan && !fa[22]) || (b_nan && !fb[22])), 3'b000, 32'h7FC00000};
        if ((a_inf && b_zero) || (b_inf && a_zero))
            return {4'b1000, 32'h7FC00000};
        if (a_inf || b_inf)
            return {4'b0000, s, 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {4'b0000, s, 31'h0};
        prod = longint'({1'b1, fa}) * longint'({1'b1, fb});
        e = int'(ea) + int'(eb) - 127;
        if (prod >= (64'd1 << 47)) begin
            sh = 24;
            e++;
        end else begin
            sh = 23;
        end
        q    = prod >> sh;
        rem  = prod & ((64'd1 << sh) - 1);
        half = 64'd1 << (sh - 1);
        if (!rm && (rem > half || (rem == half && q[0]))) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        if (e >= 255)
            return rm ? {4'b0101, s, 8'hFE, 23'h7FFFFF} : {4'b0101, s, 8'hFF, 23'h0};
        if (e <= 0)
            return {4'b0011, s, 31'h0};
        return {3'b000, rem != 0, s, e[7:0], q[22:0]};
    endfunction

    // Driver tasks
    task automatic send_op(input logic [31:0] a, input logic [31:0] b, input logic rm);
        int g;
        g = 0;
        while (!bus.in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 64'(bus.in_ready), 64'd1);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.round_mode = rm;
        bus.in_valid   = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.op_a       = $urandom;
        bus.op_b       = $urandom;
        bus.round_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic rm,
                          input int want_lat, input string name);
        int lat;
        logic [W+3:0] e;
        send_op(a, b, rm);
        wait_result(lat);
        e = exp_q.pop_front();
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_re"}, 64'(bus.re), 64'(e[W-1:0]));
        check({name, "_flags"}, 64'(bus.flags), 64'(e[W+3:W]));
        if (want_lat > 0) check({name, "_latency"}, 64'(lat), 64'(want_lat));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_op();
        int r;
        logic [7:0] e;
        logic [22:0] f;
        r = $urandom_range(0, 19);
        f = 23'($urandom);
        if (r == 0) e = 8'h00;
        else if (r == 1) begin
            e = 8'hFF;
            if ($urandom_range(0, 1) == 1) f = '0;
        end else if (r < 4) e = 8'($urandom_range(1, 40));
        else if (r < 6) e = 8'($urandom_range(200, 254));
        else e = 8'($urandom_range(100, 154));
        return {1'($urandom_range(0, 1)), e, f};
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        rm;
        logic [31:0] re;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic [31:0] hold_re;
        logic [3:0]  hold_fl;
        logic [W+3:0] e;
        int lat;

        vecs[0]  = '{32'h40400000, 32'h40800000, 1'b0, 32'h41400000, 4'b0000, 27};
        vecs[1]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40000000, 4'b0000, 27};
        vecs[2]  = '{32'h3FC00001, 32'h3FC00001, 1'b0, 32'h40100002, 4'b0001, 27};
        vecs[3]  = '{32'h3FC00001, 32'h3FC00001, 1'b1, 32'h40100001, 4'b0001, 27};
        vecs[4]  = '{32'h7F000000, 32'h40000000, 1'b0, 32'h7F800000, 4'b0101, 27};
        vecs[5]  = '{32'h7F000000, 32'h40000000, 1'b1, 32'h7F7FFFFF, 4'b0101, 27};
        vecs[6]  = '{32'h7F800000, 32'h00000000, 1'b0, 32'h7FC00000, 4'b1000, 1};
        vecs[7]  = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000, 1};
        vecs[8]  = '{32'h00800000, 32'h00800000, 1'b0, 32'h00000000, 4'b0011, 27};
        vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1};
        vecs[10] = '{32'hC0000000, 32'h7F800000, 1'b0, 32'hFF800000, 4'b0000, 1};
        vecs[11] = '{32'h80000000, 32'h40400000, 1'b1, 32'h80000000, 4'b0000, 1};
        vecs[12] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h00000000, 4'b0000, 1};
        vecs[13] = '{32'hBF800000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000, 27};

        // Reset
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.round_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_re", 64'(bus.re), 64'd0);
        check("reset_flags", 64'(bus.flags), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back({vecs[i].fl, vecs[i].re});
            run_op(vecs[i].a, vecs[i].b, vecs[i].rm, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Backpressure: result held, in_valid ignored while not idle
        bus.out_ready = 1'b0;
        send_op(32'h40400000, 32'h40400000, 1'b0);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'd27);
        hold_re = bus.re;
        hold_fl = bus.flags;
        check("bp_re", 64'(hold_re), 64'h41100000);
        check("bp_flags", 64'(hold_fl), 64'd0);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.op_a     = $urandom;
            bus.op_b     = $urandom;
            @(posedge clk);
            #1;
            check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
            check("bp_hold_re", 64'(bus.re), 64'(hold_re));
            check("bp_hold_flags", 64'(bus.flags), 64'(hold_fl));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1;
        check("bp_no_phantom", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of the multiply
        send_op(32'h40400000, 32'h40800000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", 64'(bus.in_ready), 64'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_re", 64'(bus.re), 64'd0);
        check("mid_rst_flags", 64'(bus.flags), 64'd0);
        exp_q.push_back({4'b0000, 32'h41400000});
        run_op(32'h40400000, 32'h40800000, 1'b0, 27, "after_rst");

        // Randomized operands against the model
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a, b;
            logic rm;
            a  = rand_op();
            b  = rand_op();
            rm = 1'($urandom_range(0, 1));
            e  = model(a, b, rm);
            exp_q.push_back(e);
            run_op(a, b, rm, -1, $sformatf("rand%0d_%h_%h_%0d", i, a, b, rm));
        end

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
